ghostbus_host_arb: RTL and testbench

//  Two-requester arbiter for a single ghostbus host port: serialises requests from two local masters
//  (e.g. a UART bridge and a scrub/init sequencer) onto the bus feeding the decoded register/RAM tree.

---
 rtl/ghostbus_host_arb.sv | 239 +++++++++++++++++++++++
 tb/tb_ghostbus_host_arb.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghostbus_host_arb.sv
// ---------------------------------------------------------------------------
// ghostbus_host_arb
//
// Two-requester arbiter for a single ghostbus host port. Requests from two
// local masters (for example a UART bridge and a scrub/init sequencer) are
// serialised onto the bus that feeds the decoded register/RAM tree.
// Requesters are granted round robin, only one transaction is in flight at a
// time, reads use a fixed latency, and each requester gets its own
// completion pulse.
//
// Handshake: a requester raises rqN_valid with addr/wdata/we and holds all
// four stable until rqN_ack. rqN_ack is a single-cycle pulse. The requester
// must drop or change its request at the clock edge that ends the ack cycle,
// because a valid seen in IDLE on the following cycle is a new request.
//
// Optional feature (macro GHOSTBUS_ARB_LOCK_EN):
//   When defined, the inputs rq0_lock/rq1_lock exist. If the grantee has
//   lock high in its ACK cycle, the grant is held: IDLE considers only that
//   requester until it completes a transaction with lock low. After that,
//   round robin resumes. When undefined, the lock ports do not exist and
//   round robin applies to every transaction.
//
// Parameters:
//   AW      address width
//   DW      data width
//   RD_LAT  cycles from the gb_re cycle to valid gb_din (legal 1..15)
//
// Ports:
//   clk, rst_n              clock (rising edge); asynchronous active-low reset
//   rqN_valid/addr/wdata/we request from requester N (N = 0, 1)
//   rqN_lock                grant-hold request (only with GHOSTBUS_ARB_LOCK_EN)
//   rqN_ack                 one-cycle completion pulse for requester N
//   rqN_rdata               last read data captured for requester N
//   gb_addr, gb_dout        registered bus address and write data
//   gb_we, gb_re            one-cycle bus write and read strobes
//   gb_din                  bus read data, valid RD_LAT cycles after gb_re
//   dbg_state               current FSM state (IDLE=0 ISSUE=1 WAIT=2 ACK=3)
// ---------------------------------------------------------------------------
module ghostbus_host_arb #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          rq0_valid,
    input  logic [AW-1:0] rq0_addr,
    input  logic [DW-1:0] rq0_wdata,
    input  logic          rq0_we,
    output logic          rq0_ack,
    output logic [DW-1:0] rq0_rdata,

    input  logic          rq1_valid,
    input  logic [AW-1:0] rq1_addr,
    input  logic [DW-1:0] rq1_wdata,
    input  logic          rq1_we,
    output logic          rq1_ack,
    output logic [DW-1:0] rq1_rdata,

`ifdef GHOSTBUS_ARB_LOCK_EN
    input  logic          rq0_lock,
    input  logic          rq1_lock,
`endif

    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    output logic          gb_we,
    output logic          gb_re,
    input  logic [DW-1:0] gb_din,

    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    // The counter is loaded in ISSUE and reaches zero in the cycle in which
    // gb_din is valid, i.e. RD_LAT cycles after the strobe cycle.
    localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

    state_t      state;
    state_t      state_d;

    logic        grant;       // requester owning the current transaction
    logic        last_grant;  // requester granted most recently
    logic        op_we;       // latched direction of the current transaction
    logic [3:0]  cnt;         // read latency countdown

    logic        cand0;
    logic        cand1;
    logic        sel;
    logic        do_grant;

`ifdef GHOSTBUS_ARB_LOCK_EN
    logic        locked;      // grant held for the requester in 'grant'
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and grant selection
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state;
        do_grant = 1'b0;
        cand0    = rq0_valid;
        cand1    = rq1_valid;

`ifdef GHOSTBUS_ARB_LOCK_EN
        // While locked, the other requester is invisible to the arbiter.
        if (locked) begin
            cand0 = rq0_valid && !grant;
            cand1 = rq1_valid &&  grant;
        end
`endif

        // Tie goes to the requester not granted last; otherwise whoever asks.
        if (cand0 && cand1) begin
            sel = ~last_grant;
        end else begin
            sel = cand1;
        end

        case (state)
            S_IDLE: begin
                if (cand0 || cand1) begin
                    do_grant = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = op_we ? S_ACK : S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: grant bookkeeping, bus drive, read capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;   // requester 0 wins the first tie
            op_we      <= 1'b0;
            cnt        <= 4'd0;
            gb_addr    <= '0;
            gb_dout    <= '0;
            gb_we      <= 1'b0;
            gb_re      <= 1'b0;
            rq0_rdata  <= '0;
            rq1_rdata  <= '0;
`ifdef GHOSTBUS_ARB_LOCK_EN
            locked     <= 1'b0;
`endif
        end else begin
            // Strobes are high only in the ISSUE cycle.
            gb_we <= 1'b0;
            gb_re <= 1'b0;

            if (do_grant) begin
                grant      <= sel;
                last_grant <= sel;
                if (sel) begin
                    op_we   <= rq1_we;
                    gb_addr <= rq1_addr;
                    gb_dout <= rq1_wdata;
                    gb_we   <= rq1_we;
                    gb_re   <= ~rq1_we;
                end else begin
                    op_we   <= rq0_we;
                    gb_addr <= rq0_addr;
                    gb_dout <= rq0_wdata;
                    gb_we   <= rq0_we;
                    gb_re   <= ~rq0_we;
                end
            end

            case (state)
                S_ISSUE: begin
                    // Loaded on writes as well; the value is unused there.
                    cnt <= LAT_M1;
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        if (grant) begin
                            rq1_rdata <= gb_din;
                        end else begin
                            rq0_rdata <= gb_din;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
`ifdef GHOSTBUS_ARB_LOCK_EN
                S_ACK: begin
                    // The grantee's lock in its ACK cycle decides whether
                    // the grant is held for the next transaction.
                    locked <= grant ? rq1_lock : rq0_lock;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs decoded from state
    // -----------------------------------------------------------------------
    assign rq0_ack   = (state == S_ACK) && !grant;
    assign rq1_ack   = (state == S_ACK) &&  grant;
    assign dbg_state = state;

endmodule

// File: tb/tb_ghostbus_host_arb.sv
// ---------------------------------------------------------------------------
// tb_ghostbus_host_arb
//
// Directed bench for ghostbus_host_arb. The main instance uses RD_LAT=2.
// Two extra instances with RD_LAT=1 and RD_LAT=15 cover the latency limits.
// Each completion is checked against an expected queue of {requester, rdata}
// entries. Cycle timing is checked inline by the driver tasks.
// ---------------------------------------------------------------------------
module tb_ghostbus_host_arb;

    localparam int AW  = 24;
    localparam int DW  = 32;
    localparam int LAT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT signals ----------------
    logic          rq0_valid, rq0_we, rq1_valid, rq1_we;
    logic [AW-1:0] rq0_addr, rq1_addr;
    logic [DW-1:0] rq0_wdata, rq1_wdata;
    logic          rq0_ack, rq1_ack;
    logic [DW-1:0] rq0_rdata, rq1_rdata;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_dout;
    logic          gb_we, gb_re;
    logic [DW-1:0] gb_din;
    logic [1:0]    dbg_state;
`ifdef GHOSTBUS_ARB_LOCK_EN
    logic          rq0_lock, rq1_lock;
`endif

    // ---------------- latency-limit instance signals ----------------
    logic          l1_valid, l15_valid;
    logic [AW-1:0] l1_addr, l15_addr;
    logic [DW-1:0] l1_din, l15_din;
    logic          l1_ack, l15_ack, l1_ack1, l15_ack1;
    logic [DW-1:0] l1_rdata, l15_rdata, l1_rdata1, l15_rdata1;
    logic [AW-1:0] l1_gb_addr, l15_gb_addr;
    logic [DW-1:0] l1_gb_dout, l15_gb_dout;
    logic          l1_gb_we, l15_gb_we, l1_gb_re, l15_gb_re;
    logic [1:0]    l1_dbg, l15_dbg;

    // ---------------- scoreboard ----------------
    logic [DW:0]   exp_q[$];          // {requester, expected rdata}
    logic [DW-1:0] model_rd[2];
    int            checks = 0;
    int            errors = 0;

    ghostbus_host_arb #(.AW(AW), .DW(DW), .RD_LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(rq0_valid), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata), .rq0_we(rq0_we),
        .rq0_ack(rq0_ack), .rq0_rdata(rq0_rdata),
        .rq1_valid(rq1_valid), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata), .rq1_we(rq1_we),
        .rq1_ack(rq1_ack), .rq1_rdata(rq1_rdata),
`ifdef GHOSTBUS_ARB_LOCK_EN
        .rq0_lock(rq0_lock), .rq1_lock(rq1_lock),
`endif
        .gb_addr(gb_addr), .gb_dout(gb_dout), .gb_we(gb_we), .gb_re(gb_re), .gb_din(gb_din),
        .dbg_state(dbg_state)
    );

    ghostbus_host_arb #(.AW(AW), .DW(DW), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(l1_valid), .rq0_addr(l1_addr), .rq0_wdata(32'h0), .rq0_we(1'b0),
        .rq0_ack(l1_ack), .rq0_rdata(l1_rdata),
        .rq1_valid(1'b0), .rq1_addr(24'h0), .rq1_wdata(32'h0), .rq1_we(1'b0),
        .rq1_ack(l1_ack1), .rq1_rdata(l1_rdata1),
`ifdef GHOSTBUS_ARB_LOCK_EN
        .rq0_lock(1'b0), .rq1_lock(1'b0),
`endif
        .gb_addr(l1_gb_addr), .gb_dout(l1_gb_dout), .gb_we(l1_gb_we), .gb_re(l1_gb_re),
        .gb_din(l1_din), .dbg_state(l1_dbg)
    );

    ghostbus_host_arb #(.AW(AW), .DW(DW), .RD_LAT(15)) u_lat15 (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(l15_valid), .rq0_addr(l15_addr), .rq0_wdata(32'h0), .rq0_we(1'b0),
        .rq0_ack(l15_ack), .rq0_rdata(l15_rdata),
        .rq1_valid(1'b0), .rq1_addr(24'h0), .rq1_wdata(32'h0), .rq1_we(1'b0),
        .rq1_ack(l15_ack1), .rq1_rdata(l15_rdata1),
`ifdef GHOSTBUS_ARB_LOCK_EN
        .rq0_lock(1'b0), .rq1_lock(1'b0),
`endif
        .gb_addr(l15_gb_addr), .gb_dout(l15_gb_dout), .gb_we(l15_gb_we), .gb_re(l15_gb_re),
        .gb_din(l15_din), .dbg_state(l15_dbg)
    );

    // ---------------- check helper ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- completion monitor ----------------
    always @(negedge clk) begin
        logic [DW:0] got;
        logic [DW:0] e;
        if (rst_n && (rq0_ack || rq1_ack)) begin
            check("ack_overlap", {63'b0, rq0_ack & rq1_ack}, 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_ack observed ack0=%0b ack1=%0b expected no ack", rq0_ack, rq1_ack);
            end else begin
                got = {rq1_ack, rq1_ack ? rq1_rdata : rq0_rdata};
                e   = exp_q.pop_front();
                check("ack_scoreboard", 64'(got), 64'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        rst_n     = 1'b0;
        rq0_valid = 1'b0; rq0_we = 1'b0; rq0_addr = '0; rq0_wdata = '0;
        rq1_valid = 1'b0; rq1_we = 1'b0; rq1_addr = '0; rq1_wdata = '0;
        gb_din    = '0;
        l1_valid  = 1'b0; l1_addr = '0; l1_din = '0;
        l15_valid = 1'b0; l15_addr = '0; l15_din = '0;
`ifdef GHOSTBUS_ARB_LOCK_EN
        rq0_lock  = 1'b0; rq1_lock = 1'b0;
`endif
        model_rd[0] = '0;
        model_rd[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_strobes", {62'b0, gb_we, gb_re}, 64'd0);
        check("rst_gb_addr", 64'(gb_addr), 64'd0);
        check("rst_gb_dout", 64'(gb_dout), 64'd0);
        check("rst_acks", {62'b0, rq0_ack, rq1_ack}, 64'd0);
        check("rst_rdata", {rq0_rdata, rq1_rdata}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single transaction on an otherwise idle main DUT. The grant edge is the
    // first rising edge after valid is driven (edge k).
    task automatic main_txn(input int id, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        int last;
        @(negedge clk);
        if (id == 0) begin
            rq0_valid = 1'b1; rq0_we = we; rq0_addr = a; rq0_wdata = wd;
        end else begin
            rq1_valid = 1'b1; rq1_we = we; rq1_addr = a; rq1_wdata = wd;
        end
        if (!we) model_rd[id] = rd;
        exp_q.push_back({1'(id), model_rd[id]});
        last = we ? 2 : LAT + 2;
        @(posedge clk);
        #1;
        for (int c = 1; c <= last; c++) begin
            gb_din = (!we && c == LAT + 1) ? rd : (32'hDEAD_0000 | 32'(c));
            if (c == 1) begin
                check("strobe_we", {63'b0, gb_we}, {63'b0, we});
                check("strobe_re", {63'b0, gb_re}, {63'b0, ~we});
                check("strobe_addr", 64'(gb_addr), 64'(a));
                check("strobe_dout", 64'(gb_dout), 64'(wd));
            end
            if (c == 2) check("strobe_one_cycle", {62'b0, gb_we, gb_re}, 64'd0);
            check("ack_timing", {63'b0, (id == 0) ? rq0_ack : rq1_ack}, {63'b0, c == last});
            if (c == last) begin
                check("other_rdata_held", 64'((id == 0) ? rq1_rdata : rq0_rdata),
                      64'(model_rd[1 - id]));
                @(negedge clk);
                if (id == 0) rq0_valid = 1'b0; else rq1_valid = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Read on one of the latency-limit instances.
    task automatic lat_read(input int lat, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] dv;
        logic          ack_v, re_v;
        logic [DW-1:0] rdata_v;
        @(negedge clk);
        if (lat == 1) begin l1_valid = 1'b1; l1_addr = a; end
        else begin l15_valid = 1'b1; l15_addr = a; end
        @(posedge clk);
        #1;
        for (int c = 1; c <= lat + 2; c++) begin
            dv = (c == lat + 1) ? d : (32'hBAD0_0000 | 32'(c));
            if (lat == 1) l1_din = dv; else l15_din = dv;
            ack_v   = (lat == 1) ? l1_ack : l15_ack;
            re_v    = (lat == 1) ? l1_gb_re : l15_gb_re;
            rdata_v = (lat == 1) ? l1_rdata : l15_rdata;
            if (c == 1) check($sformatf("lat%0d_re", lat), {63'b0, re_v}, 64'd1);
            check($sformatf("lat%0d_ack_timing", lat), {63'b0, ack_v}, {63'b0, c == lat + 2});
            if (c == lat + 2) begin
                check($sformatf("lat%0d_rdata", lat), 64'(rdata_v), 64'(d));
                @(negedge clk);
                if (lat == 1) l1_valid = 1'b0; else l15_valid = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Bounded wait for any ack on the main DUT; returns at the negedge of
    // the ack cycle so the caller can change its request before the edge.
    task automatic wait_ack(output int id);
        id = -1;
        for (int i = 0; i < 64 && id < 0; i++) begin
            @(negedge clk);
            if (rq0_ack) id = 0;
            else if (rq1_ack) id = 1;
        end
        if (id < 0) begin
            checks++;
            errors++;
            $error("FAIL ack_timeout observed no ack expected ack within 64 cycles");
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog observed no finish expected finish by 200000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int id;
        int n0;
        int n1;

        do_reset();

        // Both requesters valid straight out of reset; grants alternate 0,1,0,1.
        rq0_valid = 1'b1; rq0_we = 1'b1; rq0_addr = 24'h000100; rq0_wdata = 32'h11;
        rq1_valid = 1'b1; rq1_we = 1'b1; rq1_addr = 24'h000200; rq1_wdata = 32'h22;
        exp_q.push_back({1'b0, model_rd[0]});
        exp_q.push_back({1'b1, model_rd[1]});
        exp_q.push_back({1'b0, model_rd[0]});
        exp_q.push_back({1'b1, model_rd[1]});
        n0 = 0;
        n1 = 0;
        repeat (4) begin
            wait_ack(id);
            if (id == 0) begin
                n0++;
                if (n0 == 2) rq0_valid = 1'b0; else rq0_addr = 24'h000104;
            end else if (id == 1) begin
                n1++;
                if (n1 == 2) rq1_valid = 1'b0; else rq1_addr = 24'h000204;
            end
        end
        check("rr_grant_counts", {32'(n0), 32'(n1)}, {32'd2, 32'd2});
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;

        // Basic write, then read with the example data.
        main_txn(0, 1'b1, 24'h000040, 32'h5, 32'h0);
        main_txn(1, 1'b0, 24'h000010, 32'h0, 32'h7c);

        // Randomised single transactions on alternating paths.
        repeat (6) begin
            main_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     24'($urandom_range(0, 24'hFFFFFF)), $urandom, $urandom);
        end

        // Reset in the middle of a read: outputs clear at once, no ack follows.
        @(negedge clk);
        rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = 24'h000020;
        @(posedge clk); #1;          // ISSUE
        @(posedge clk); #2;          // WAIT
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 64'(dbg_state), 64'd0);
        check("async_rst_strobes", {62'b0, gb_we, gb_re}, 64'd0);
        check("async_rst_gb_addr", 64'(gb_addr), 64'd0);
        check("async_rst_gb_dout", 64'(gb_dout), 64'd0);
        check("async_rst_acks", {62'b0, rq0_ack, rq1_ack}, 64'd0);
        check("async_rst_rdata", {rq0_rdata, rq1_rdata}, 64'd0);
        rq1_valid   = 1'b0;
        model_rd[0] = '0;
        model_rd[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("no_ack_after_reset", {62'b0, rq0_ack, rq1_ack}, 64'd0);
        end
        main_txn(1, 1'b0, 24'h000030, 32'h0, 32'h1234_5678);
        main_txn(0, 1'b1, 24'h000034, 32'hCAFE_F00D, 32'h0);

        // Latency limits.
        lat_read(1, 24'h000050, 32'hA1A1_0001);
        lat_read(15, 24'h000060, 32'hF15F_0015);
        lat_read(1, 24'h000054, 32'h0000_00FF);

`ifdef GHOSTBUS_ARB_LOCK_EN
        // rq0 holds the grant for three reads while rq1 waits.
        do_reset();
        rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 24'h000300; rq0_lock = 1'b1;
        rq1_valid = 1'b1; rq1_we = 1'b1; rq1_addr = 24'h000400; rq1_wdata = 32'h44;
        gb_din = 32'h0C0D_0000;
        exp_q.push_back({1'b0, 32'h0C0D_0000});
        exp_q.push_back({1'b0, 32'h0C0D_0001});
        exp_q.push_back({1'b0, 32'h0C0D_0002});
        exp_q.push_back({1'b1, model_rd[1]});
        model_rd[0] = 32'h0C0D_0002;
        wait_ack(id);
        rq0_addr = 24'h000304;
        gb_din   = 32'h0C0D_0001;
        wait_ack(id);
        rq0_addr = 24'h000308;
        gb_din   = 32'h0C0D_0002;
        @(negedge clk);
        rq0_lock = 1'b0;
        wait_ack(id);
        rq0_valid = 1'b0;
        wait_ack(id);
        check("lock_final_grant", 64'(id), 64'd1);
        rq1_valid = 1'b0;
`endif

        repeat (4) @(posedge clk);
        check("queue_drained_end", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
